collatz_dp: RTL and testbench

Datapath for the odd/even step engine: holds the working value `x`, the step counter `k` and status flags, and updates them from the strobes issued each cycle by the step controller. Returns `co` (current value), `r` (parity) and `k` to the controller, which decides the next step from them. It sits directly beside the controller in the step-engine top level; one seed is processed per start request.

---
 rtl/collatz_pkg.sv | 18 +
 rtl/collatz_dp_if.sv | 28 ++
 rtl/collatz_dp_sat_counter.sv | 22 ++
 rtl/collatz_dp.sv | 99 +++++++++
 tb/tb_collatz_dp.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/collatz_pkg.sv
// Shared widths and the step-controller strobe bundle for the collatz step engine.
package collatz_pkg;

   localparam int X_W = 16;
   localparam int K_W = 20;

   typedef struct packed {
      logic Mx;
      logic Rx;
      logic Ik;
      logic Pk;
      logic Sk;
      logic Mr;
      logic Pr;
      logic Ir;
   } step_ctrl_t;

endpackage

// File: rtl/collatz_dp_if.sv
// Controller <-> datapath bundle: seed, strobes in; value, count and status out.
interface collatz_dp_if import collatz_pkg::*; #(
   parameter int X_W = collatz_pkg::X_W,
   parameter int K_W = collatz_pkg::K_W
);

   logic [X_W-1:0] x_in;
   step_ctrl_t     ctl;
   logic [X_W-1:0] co;
   logic           r;
   logic [K_W-1:0] k;
   logic [X_W-1:0] peak;
   logic           ovf;
   logic           err;
   logic           done;
   logic [K_W-1:0] result_k;

   modport master (
      output x_in, ctl,
      input  co, r, k, peak, ovf, err, done, result_k
   );

   modport slave (
      input  x_in, ctl,
      output co, r, k, peak, ovf, err, done, result_k
   );

endinterface

// File: rtl/collatz_dp_sat_counter.sv
// Up-counter with synchronous clear (priority) that sticks at all-ones.
module sat_counter import collatz_pkg::*; #(
   parameter int W = collatz_pkg::K_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && !(&q)) begin
         q <= q + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/collatz_dp.sv
// Collatz step datapath: working value, step count, peak tracking and sticky flags,
// driven by per-cycle strobes from the step controller.
module collatz_dp import collatz_pkg::*; #(
   parameter int X_W = collatz_pkg::X_W,
   parameter int K_W = collatz_pkg::K_W
) (
   input logic         clk,
   input logic         rst,
   collatz_dp_if.slave bus
);

   step_ctrl_t     c;
   logic [X_W-1:0] x;
   logic [X_W-1:0] x_new;
   logic [X_W-1:0] peak;
   logic [X_W+1:0] odd;
   logic [K_W-1:0] k;
   logic [K_W-1:0] result_k;
   logic           do_odd;
   logic           do_even;
   logic           bad;
   logic           ovf;
   logic           err;
   logic           ir_q;
   logic           done;

   assign c = bus.ctl;

   // 3x+1 carried in two extra bits so the overflow is visible before truncation
   assign odd = {2'b00, x} + {1'b0, x, 1'b0} + {{(X_W+1){1'b0}}, 1'b1};

   always_comb begin
      do_odd  = c.Mx & c.Mr & ~c.Pr;
      do_even = c.Mx & c.Pr & ~c.Mr;
      bad     = c.Mx & (c.Mr ~^ c.Pr);
      x_new   = x;
      if (do_odd) begin
         x_new = odd[X_W-1:0];
      end else if (do_even) begin
         x_new = x >> 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x        <= '0;
         peak     <= '0;
         ovf      <= 1'b0;
         err      <= 1'b0;
         ir_q     <= 1'b1;
         done     <= 1'b0;
         result_k <= '0;
      end else begin
         if (c.Rx) begin
            x    <= bus.x_in;
            peak <= bus.x_in;
            ovf  <= 1'b0;
            err  <= 1'b0;
         end else begin
            if (do_odd || do_even) begin
               x <= x_new;
               if (x_new > peak) begin
                  peak <= x_new;
               end
            end
            if (do_odd && (|odd[X_W+1:X_W])) begin
               ovf <= 1'b1;
            end
            if (bad) begin
               err <= 1'b1;
            end
         end
         // ir_q resets high so an Ir already high at reset release is not an edge
         ir_q <= c.Ir;
         done <= c.Ir & ~ir_q;
         if (c.Ir && !ir_q) begin
            result_k <= k;
         end
      end
   end

   sat_counter #(.W(K_W)) u_k (
      .clk (clk),
      .rst (rst),
      .clr (c.Sk),
      .en  (c.Ik | c.Pk),
      .q   (k)
   );

   assign bus.co       = x;
   assign bus.r        = x[0];
   assign bus.k        = k;
   assign bus.peak     = peak;
   assign bus.ovf      = ovf;
   assign bus.err      = err;
   assign bus.done     = done;
   assign bus.result_k = result_k;

endmodule

// File: tb/tb_collatz_dp.sv
// Self-checking bench for collatz_dp against an arithmetic Collatz reference model.
module tb_collatz_dp;
   import collatz_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   collatz_dp_if bus ();
   collatz_dp_if #(.K_W(8)) bus_s ();

   collatz_dp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // narrow-counter instance so saturation is reachable in a short run
   collatz_dp #(.K_W(8)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      logic ir;
      ir = bus.ctl.Ir;
      bus.ctl = '0;
      bus.ctl.Ir = ir;
   endtask

   task automatic load(input int v);
      idle();
      bus.x_in = 16'(v);
      bus.ctl.Rx = 1'b1;
      bus.ctl.Sk = 1'b1;
      tick();
      idle();
   endtask

   // Walks a seed with odd/even strobes chosen from the model value; checks every step.
   task automatic run_seed(input int seed, input int limit, output int steps, output int seq[$]);
      int mx, mk, mpk, t;
      bit movf;
      seq = {};
      bus.ctl.Ir = 1'b0;
      load(seed);
      mx = seed; mk = 0; mpk = seed; movf = 0;
      n_cmp++;
      if (bus.co !== 16'(mx) || bus.k !== 20'd0 || bus.peak !== 16'(mpk)) begin
         n_bad++;
         $display("FAIL load seed=%0d: co=%0d k=%0d peak=%0d, want co=%0d k=0 peak=%0d",
                  seed, bus.co, bus.k, bus.peak, mx, mpk);
      end
      while (mx != 1 && mk < limit) begin
         bus.ctl.Mx = 1'b1;
         if (mx % 2 == 1) begin
            bus.ctl.Mr = 1'b1;
            bus.ctl.Ik = 1'b1;
            t = 3 * mx + 1;
            if (t > 65535) movf = 1;
            mx = t % 65536;
         end else begin
            bus.ctl.Pr = 1'b1;
            bus.ctl.Pk = 1'b1;
            mx = mx / 2;
         end
         mk++;
         if (mx > mpk) mpk = mx;
         tick();
         idle();
         seq.push_back(int'(bus.co));
         n_cmp++;
         if (bus.co !== 16'(mx) || bus.r !== 1'(mx % 2) || bus.k !== 20'(mk) ||
             bus.peak !== 16'(mpk) || bus.ovf !== movf || bus.err !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL step seed=%0d n=%0d: co=%0d r=%0b k=%0d peak=%0d ovf=%0b err=%0b done=%0b, want co=%0d k=%0d peak=%0d ovf=%0b",
                     seed, mk, bus.co, bus.r, bus.k, bus.peak, bus.ovf, bus.err, bus.done, mx, mk, mpk, movf);
         end
      end
      steps = mk;
   endtask

   task automatic test_reset;
      n_cmp++;
      if (bus.co !== 16'd0 || bus.r !== 1'b0 || bus.k !== 20'd0 || bus.peak !== 16'd0 ||
          bus.ovf !== 1'b0 || bus.err !== 1'b0 || bus.done !== 1'b0 || bus.result_k !== 20'd0) begin
         n_bad++;
         $display("FAIL reset: co=%0h k=%0h peak=%0h ovf=%0b err=%0b done=%0b result_k=%0h, want all zero",
                  bus.co, bus.k, bus.peak, bus.ovf, bus.err, bus.done, bus.result_k);
      end
      tick();
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_no_done: done=%0b want 0", bus.done);
      end
   endtask

   task automatic test_seed6;
      int steps;
      int seq[$];
      int exp_seq[8] = '{3, 10, 5, 16, 8, 4, 2, 1};
      run_seed(6, 50, steps, seq);
      n_cmp++;
      if (seq.size() != 8) begin
         n_bad++;
         $display("FAIL seed6_len: got %0d steps want 8", seq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (seq[i] != exp_seq[i]) begin
               n_bad++;
               $display("FAIL seed6_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]);
            end
         end
      end
      n_cmp++;
      if (bus.k !== 20'd8 || bus.peak !== 16'd16 || bus.ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL seed6_final: k=%0d peak=%0d ovf=%0b want 8 16 0", bus.k, bus.peak, bus.ovf);
      end
      // Ir rise together with Sk: result_k captures the count before the clear
      bus.ctl.Ir = 1'b1;
      bus.ctl.Sk = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.done !== 1'b1 || bus.result_k !== 20'd8 || bus.k !== 20'd0) begin
         n_bad++;
         $display("FAIL seed6_done: done=%0b result_k=%0d k=%0d want 1 8 0", bus.done, bus.result_k, bus.k);
      end
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.result_k !== 20'd8) begin
         n_bad++;
         $display("FAIL seed6_pulse: done=%0b result_k=%0d want 0 8", bus.done, bus.result_k);
      end
   endtask

   task automatic test_seed27;
      int steps;
      int seq[$];
      run_seed(27, 200, steps, seq);
      n_cmp++;
      if (bus.co !== 16'd1 || bus.k !== 20'd111 || bus.peak !== 16'd9232 || bus.ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL seed27: co=%0d k=%0d peak=%0d ovf=%0b want 1 111 9232 0",
                  bus.co, bus.k, bus.peak, bus.ovf);
      end
      bus.ctl.Ir = 1'b1;
      tick();
      n_cmp++;
      if (bus.done !== 1'b1 || bus.result_k !== 20'd111) begin
         n_bad++;
         $display("FAIL seed27_done: done=%0b result_k=%0d want 1 111", bus.done, bus.result_k);
      end
   endtask

   task automatic test_random;
      int steps;
      int seq[$];
      for (int i = 0; i < 6; i++) begin
         run_seed(int'($urandom_range(2, 65535)), 250, steps, seq);
      end
   endtask

   task automatic test_ovf;
      load(16'hFFFF);
      bus.ctl.Mx = 1'b1;
      bus.ctl.Mr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.co !== 16'hFFFE || bus.ovf !== 1'b1 || bus.peak !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL ovf_set: co=%0h ovf=%0b peak=%0h want fffe 1 ffff", bus.co, bus.ovf, bus.peak);
      end
      // load coinciding with an overflowing odd step: load wins and clears
      bus.x_in = 16'd5;
      bus.ctl.Rx = 1'b1;
      bus.ctl.Mx = 1'b1;
      bus.ctl.Mr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.co !== 16'd5 || bus.ovf !== 1'b0 || bus.peak !== 16'd5) begin
         n_bad++;
         $display("FAIL ovf_clear: co=%0h ovf=%0b peak=%0h want 5 0 5", bus.co, bus.ovf, bus.peak);
      end
   endtask

   task automatic test_err;
      load(7);
      bus.ctl.Mx = 1'b1;
      bus.ctl.Mr = 1'b1;
      bus.ctl.Pr = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.co !== 16'd7 || bus.err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_both: co=%0d err=%0b want 7 1", bus.co, bus.err);
      end
      load(9);
      n_cmp++;
      if (bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: err=%0b want 0", bus.err);
      end
      bus.ctl.Mx = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.co !== 16'd9 || bus.err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_none: co=%0d err=%0b want 9 1", bus.co, bus.err);
      end
   endtask

   task automatic test_saturation;
      int mk;
      mk = 0;
      bus_s.ctl = '0;
      bus_s.ctl.Sk = 1'b1;
      tick();
      bus_s.ctl = '0;
      for (int i = 0; i < 300; i++) begin
         if (i % 3 == 0) bus_s.ctl.Pk = 1'b1; else bus_s.ctl.Ik = 1'b1;
         tick();
         bus_s.ctl = '0;
         if (mk < 255) mk++;
         if (i % 25 == 0 || i > 250) begin
            n_cmp++;
            if (bus_s.k !== 8'(mk)) begin
               n_bad++;
               $display("FAIL sat_count i=%0d: k=%0d want %0d", i, bus_s.k, mk);
            end
         end
      end
      bus_s.ctl.Sk = 1'b1;
      bus_s.ctl.Ik = 1'b1;
      tick();
      bus_s.ctl = '0;
      n_cmp++;
      if (bus_s.k !== 8'd0) begin
         n_bad++;
         $display("FAIL sat_clear: k=%0d want 0", bus_s.k);
      end
   endtask

   task automatic test_reset_mid;
      bus.ctl.Ir = 1'b0;
      load(3);
      bus.ctl.Mx = 1'b1;
      bus.ctl.Mr = 1'b1;
      bus.ctl.Ik = 1'b1;
      tick();
      idle();
      n_cmp++;
      if (bus.co !== 16'd10 || bus.k !== 20'd1) begin
         n_bad++;
         $display("FAIL mid_pre: co=%0d k=%0d want 10 1", bus.co, bus.k);
      end
      bus.ctl.Ir = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.co !== 16'd0 || bus.k !== 20'd0 || bus.peak !== 16'd0 || bus.ovf !== 1'b0 ||
          bus.err !== 1'b0 || bus.done !== 1'b0 || bus.result_k !== 20'd0) begin
         n_bad++;
         $display("FAIL mid_async: co=%0d k=%0d peak=%0d done=%0b result_k=%0d want all zero",
                  bus.co, bus.k, bus.peak, bus.done, bus.result_k);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus.done !== 1'b0 || bus.co !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_release c%0d: done=%0b co=%0d want 0 0", i, bus.done, bus.co);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.x_in = '0;
      bus.ctl = '0;
      bus.ctl.Ir = 1'b1;
      bus_s.x_in = '0;
      bus_s.ctl = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_seed6();
      test_seed27();
      test_random();
      test_ovf();
      test_err();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
